// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencing controller.
package mdu_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops 0..3 occupy the unit; MTHI/MTLO and reserved codes do not.
  function automatic logic is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] safe_rt_u;
  logic [31:0] safe_rt_s;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        div_zero;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    prod_s    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u    = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero  = (rt_val == 32'd0);
    abs_rs    = neg_if(rs_val, rs_val[31]);
    abs_rt    = neg_if(rt_val, rt_val[31]);
    safe_rt_u = div_zero ? 32'd1 : rt_val;
    safe_rt_s = div_zero ? 32'd1 : abs_rt;
    q_u       = rs_val / safe_rt_u;
    r_u       = rs_val % safe_rt_u;
    q_mag     = abs_rs / safe_rt_s;
    r_mag     = abs_rs % safe_rt_s;
  end

  // Result select; a zero divisor hands back the current HI/LO so nothing changes.
  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (div_zero) begin
          res_hi = cur_hi;
          res_lo = cur_lo;
        end else begin
          res_hi = neg_if(r_mag, rs_val[31]);
          res_lo = neg_if(q_mag, rs_val[31] ^ rt_val[31]);
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          res_hi = cur_hi;
          res_lo = cur_lo;
        end else begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latency countdown, HI/LO ownership and D-stage stall request.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             busy_s;
  logic             stall_s;

  mdu_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Next-state: launch/MTxx in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith(md_op)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = md_op[1] ? DIV_N : MULT_N;
            state_d   = ST_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, countdown and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // MTHI/MTLO in E never stall D; only an occupied or launching unit does.
  always_comb begin
    busy_s  = (state_q == ST_RUN);
    stall_s = d_is_md & (busy_s | (start & is_arith(md_op)));
  end

  assign busy     = busy_s;
  assign stall_md = stall_s;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table through a result scoreboard plus corner sequences.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
    logic        dmd;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  vec_t vecs[9];

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Issuing while occupied is a protocol violation the bench must never commit.
  always @(posedge clk) begin
    if (reset === 1'b1 && start === 1'b1 && busy === 1'b1) begin
      errors++;
      $display("FAIL protocol_start_while_busy actual=1 required=0");
    end
  end

  // Caller is at a negedge; returns at the negedge after done has dropped.
  task automatic run_vec(input vec_t v);
    int   n;
    res_t e;
    start   = 1'b1;
    md_op   = v.op;
    rs_val  = v.rs;
    rt_val  = v.rt;
    d_is_md = v.dmd;
    sb.push_back('{hi: v.hi, lo: v.lo});
    #1;
    chk("stall_start", {63'd0, stall_md}, {63'd0, v.dmd});
    @(negedge clk);
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("stall_run", {63'd0, stall_md}, {63'd0, v.dmd});
      chk("done_early", {63'd0, done}, 64'd0);
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(v.ncyc));
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("stall_fall", {63'd0, stall_md}, 64'd0);
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("hi", {32'd0, hi}, {32'd0, e.hi});
      chk("lo", {32'd0, lo}, {32'd0, e.lo});
    end else begin
      chk("scoreboard_pop", 64'(sb.size()), 64'd0);
    end
    @(negedge clk);
    chk("done_clear", {63'd0, done}, 64'd0);
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] val);
    start   = 1'b1;
    md_op   = op;
    rs_val  = val;
    rt_val  = 32'd0;
    #1;
    chk("mt_stall", {63'd0, stall_md}, 64'd0);
    chk("mt_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mt_done", {63'd0, done}, 64'd0);
    chk("mt_busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    vec_t v;
    logic seen_done;
    vecs[0] = '{op: 3'd0, rs: 32'hFFFFFFFE, rt: 32'd3, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, ncyc: MULT_N, dmd: 1'b1};
    vecs[1] = '{op: 3'd1, rs: 32'hFFFFFFFE, rt: 32'd3, hi: 32'h00000002, lo: 32'hFFFFFFFA, ncyc: MULT_N, dmd: 1'b0};
    vecs[2] = '{op: 3'd2, rs: 32'hFFFFFFF9, rt: 32'd2, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, ncyc: DIV_N,  dmd: 1'b1};
    vecs[3] = '{op: 3'd3, rs: 32'd7,        rt: 32'd2, hi: 32'd1,        lo: 32'd3,        ncyc: DIV_N,  dmd: 1'b0};
    vecs[4] = '{op: 3'd2, rs: 32'h80000000, rt: 32'hFFFFFFFF, hi: 32'd0, lo: 32'h80000000, ncyc: DIV_N,  dmd: 1'b0};
    vecs[5] = '{op: 3'd2, rs: 32'd7,        rt: 32'hFFFFFFFE, hi: 32'd1, lo: 32'hFFFFFFFD, ncyc: DIV_N,  dmd: 1'b1};
    vecs[6] = '{op: 3'd0, rs: 32'h80000000, rt: 32'h80000000, hi: 32'h40000000, lo: 32'd0, ncyc: MULT_N, dmd: 1'b0};
    vecs[7] = '{op: 3'd1, rs: 32'hFFFFFFFF, rt: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'd1, ncyc: MULT_N, dmd: 1'b1};
    vecs[8] = '{op: 3'd3, rs: 32'h80000000, rt: 32'hFFFFFFFF, hi: 32'h80000000, lo: 32'd0, ncyc: DIV_N, dmd: 1'b0};

    reset   = 1'b0;
    start   = 1'b0;
    md_op   = 3'd0;
    rs_val  = 32'd0;
    rt_val  = 32'd0;
    d_is_md = 1'b0;
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Zero divisor keeps HI/LO but still takes the full latency and pulses done.
    d_is_md = 1'b0;
    mt_op(3'd4, 32'h00000011);
    mt_op(3'd5, 32'h00000022);
    v = '{op: 3'd3, rs: 32'd5, rt: 32'd0, hi: 32'h11, lo: 32'h22, ncyc: DIV_N, dmd: 1'b0};
    run_vec(v);
    v = '{op: 3'd2, rs: 32'hFFFFFFFB, rt: 32'd0, hi: 32'h11, lo: 32'h22, ncyc: DIV_N, dmd: 1'b1};
    run_vec(v);

    // MTHI then MTLO back to back with a decode-side md instruction present.
    d_is_md = 1'b1;
    mt_op(3'd4, 32'hDEADBEEF);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
    chk("mthi_lo", {32'd0, lo}, {32'd0, 32'h22});
    mt_op(3'd5, 32'h12345678);
    chk("mtlo_hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h12345678});
    mt_op(3'd6, 32'h0BADF00D);
    chk("rsv_hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
    chk("rsv_lo", {32'd0, lo}, {32'd0, 32'h12345678});
    d_is_md = 1'b0;

    // Async reset two cycles into a DIV aborts it with no later commit.
    start  = 1'b1;
    md_op  = 3'd2;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_commit", {63'd0, seen_done}, 64'd0);
    chk("abort_hi_after", {32'd0, hi}, 64'd0);
    chk("abort_lo_after", {32'd0, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
